// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Predicts the next fetch PC in IF and raises a redirect when EX disagrees with the prediction.
module branch_target_buffer #(
  parameter int unsigned ENTRY_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_if,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_br,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_target,
  output logic [31:0] br_count,
  output logic [31:0] miss_count
);

  localparam int unsigned Entries = 1 << ENTRY_BITS;
  localparam int unsigned TagW    = 30 - ENTRY_BITS;

  logic                  valid_q  [Entries];
  logic [TagW-1:0]       tag_q    [Entries];
  logic [31:0]           target_q [Entries];
  logic [1:0]            cnt_q    [Entries];
  logic [31:0]           br_count_q;
  logic [31:0]           miss_count_q;

  logic [ENTRY_BITS-1:0] idx_if;
  logic [TagW-1:0]       tag_if;
  logic                  hit_if;
  logic [ENTRY_BITS-1:0] ex_idx;
  logic [TagW-1:0]       ex_tag;
  logic                  ex_hit;
  logic                  upd;

  assign idx_if = pc_if[ENTRY_BITS+1:2];
  assign tag_if = pc_if[31:ENTRY_BITS+2];
  assign ex_idx = ex_pc[ENTRY_BITS+1:2];
  assign ex_tag = ex_pc[31:ENTRY_BITS+2];

  // Lookup reads registered state only; same-cycle updates are not bypassed.
  always_comb begin
    hit_if      = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    pred_taken  = hit_if && cnt_q[idx_if][1];
    pred_target = pred_taken ? target_q[idx_if] : pc_if + 32'd4;
  end

  always_comb begin
    upd    = ex_valid && ex_is_br;
    ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    mispredict = 1'b0;
    if (ex_valid) begin
      if (ex_is_br) begin
        mispredict = (ex_taken != ex_pred_taken) ||
                     (ex_taken && (ex_target != ex_pred_target));
      end else begin
        mispredict = ex_pred_taken;
      end
    end
    redirect_target = (ex_is_br && ex_taken) ? ex_target : ex_pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b01;
      end
      br_count_q   <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      if (upd) begin
        if (ex_hit) begin
          if (ex_taken) begin
            if (cnt_q[ex_idx] != 2'b11) cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'd1;
          end else begin
            if (cnt_q[ex_idx] != 2'b00) cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          valid_q[ex_idx] <= 1'b1;
          cnt_q[ex_idx]   <= 2'b10;
        end
        if (br_count_q != 32'hFFFF_FFFF) br_count_q <= br_count_q + 32'd1;
      end
      if (mispredict && (miss_count_q != 32'hFFFF_FFFF)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  // On a hit the tag is unchanged, so rewriting it keeps hit and allocate on one path.
  always_ff @(posedge clk) begin
    if (upd && ex_taken) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= ex_target;
    end
  end

  assign br_count   = br_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus randomized traffic
// compared against a table-level behavioural model.
module tb_branch_target_buffer;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_br;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_target;
  logic [31:0] br_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  branch_target_buffer #(.ENTRY_BITS(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_if          (pc_if),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_br       (ex_is_br),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_target(redirect_target),
    .br_count       (br_count),
    .miss_count     (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 64 entries, index = (pc / 4) mod 64, tag = pc / 256.
  bit          m_valid  [64];
  logic [31:0] m_tag    [64];
  logic [31:0] m_target [64];
  int          m_cnt    [64];
  logic [31:0] m_br;
  logic [31:0] m_miss;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd64);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i = m_idx(pc);
    return m_valid[i] && (m_tag[i] == pc / 32'd256);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
    return m_pred(pc) ? m_target[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mp();
    if (!ex_valid) return 1'b0;
    if (!ex_is_br) return ex_pred_taken;
    return (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
  endfunction

  function automatic logic [31:0] m_redir();
    return (ex_is_br && ex_taken) ? ex_target : ex_pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
    m_br   = 0;
    m_miss = 0;
  endtask

  // Applies the model's view of the coming edge, then advances one clock.
  task automatic cycle();
    int  i   = m_idx(ex_pc);
    bit  hit = m_hit(ex_pc);
    if (m_mp() && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
    if (ex_valid && ex_is_br) begin
      if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      if (hit) begin
        if (ex_taken) begin
          m_cnt[i]    = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_target[i] = ex_target;
        end else begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (ex_taken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = ex_pc / 32'd256;
        m_target[i] = ex_target;
        m_cnt[i]    = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit br, input bit t,
                       input logic [31:0] tg, input bit pt, input logic [31:0] ptg);
    ex_valid = v; ex_pc = pc; ex_is_br = br; ex_taken = t;
    ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    pc_if = 32'h100;
    m_reset();
    #12;
    checks++; if (pred_taken !== 1'b0) begin errors++;
      $display("FAIL reset_pred_taken got=%0b exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin errors++;
      $display("FAIL reset_pred_target got=%h exp=00000104", pred_target); end
    checks++; if (br_count !== 32'd0 || miss_count !== 32'd0) begin errors++;
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", br_count, miss_count); end
    drive(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++;
      $display("FAIL reset_mispredict_follows_ex got=%0b exp=1", mispredict); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_branch();
    pc_if = 32'h100;
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin errors++;
      $display("FAIL cold_lookup got=%0b/%h exp=0/00000104", pred_taken, pred_target); end
    checks++; if (mispredict !== 1'b1 || redirect_target !== 32'h80) begin errors++;
      $display("FAIL cold_redirect got=%0b/%h exp=1/00000080", mispredict, redirect_target); end
    cycle();
    idle();
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin errors++;
      $display("FAIL cold_after_alloc got=%0b/%h exp=1/00000080", pred_taken, pred_target); end
    checks++; if (br_count !== 32'd1 || miss_count !== 32'd1) begin errors++;
      $display("FAIL cold_counters got=%0d/%0d exp=1/1", br_count, miss_count); end
  endtask

  task automatic test_saturation();
    pc_if = 32'h100;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, m_pred(32'h100), m_pred_tgt(32'h100));
      cycle();
    end
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 32'h80);
    cycle();
    idle();
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin errors++;
      $display("FAIL sat_one_nt got=%0b/%h exp=1/00000080", pred_taken, pred_target); end
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 32'h80);
    cycle();
    idle();
    #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin errors++;
      $display("FAIL sat_two_nt got=%0b/%h exp=0/00000104", pred_taken, pred_target); end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0, 32'h104);
      cycle();
    end
    // From a floor of 00 a single taken only reaches 01.
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
    cycle();
    idle();
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++;
      $display("FAIL sat_floor got=%0b exp=0", pred_taken); end
    checks++; if (br_count !== m_br || miss_count !== m_miss) begin errors++;
      $display("FAIL sat_counters got=%0d/%0d exp=%0d/%0d", br_count, miss_count, m_br, m_miss);
    end
  endtask

  task automatic test_aliasing();
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
    cycle();
    drive(1'b1, 32'h200, 1'b1, 1'b1, 32'h40, 1'b0, 32'h204);
    cycle();
    idle();
    pc_if = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin errors++;
      $display("FAIL alias_evicted got=%0b/%h exp=0/00000104", pred_taken, pred_target); end
    pc_if = 32'h200;
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h40) begin errors++;
      $display("FAIL alias_new got=%0b/%h exp=1/00000040", pred_taken, pred_target); end
  endtask

  task automatic test_target_change();
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
    cycle();
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
    cycle();
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'hC0, 1'b1, 32'h80);
    #1;
    checks++; if (mispredict !== 1'b1 || redirect_target !== 32'hC0) begin errors++;
      $display("FAIL tgt_redirect got=%0b/%h exp=1/000000c0", mispredict, redirect_target); end
    cycle();
    idle();
    pc_if = 32'h100;
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'hC0) begin errors++;
      $display("FAIL tgt_lookup got=%0b/%h exp=1/000000c0", pred_taken, pred_target); end
  endtask

  task automatic test_same_cycle();
    pc_if = 32'h300;
    drive(1'b1, 32'h300, 1'b1, 1'b1, 32'h500, 1'b0, 32'h304);
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++;
      $display("FAIL same_cycle_bypass got=%0b exp=0", pred_taken); end
    cycle();
    idle();
    #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h500) begin errors++;
      $display("FAIL same_cycle_next got=%0b/%h exp=1/00000500", pred_taken, pred_target); end
    drive(1'b0, 32'h300, 1'b1, 1'b0, 32'h0, 1'b1, 32'h500);
    #1;
    checks++; if (mispredict !== 1'b0) begin errors++;
      $display("FAIL invalid_mispredict got=%0b exp=0", mispredict); end
    cycle();
    idle();
    #1;
    checks++; if (br_count !== m_br || miss_count !== m_miss || pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL invalid_no_effect got=%0d/%0d/%0b exp=%0d/%0d/1",
               br_count, miss_count, pred_taken, m_br, m_miss);
    end
  endtask

  task automatic test_random();
    logic [31:0] pcs [8] = '{32'h100, 32'h200, 32'h104, 32'h1100, 32'h3FC,
                             32'h8000_0100, 32'h300, 32'hFFFF_FFFC};
    logic [31:0] tgts [4] = '{32'h80, 32'h40, 32'hC0, 32'h0};
    for (int n = 0; n < 400; n++) begin
      logic [31:0] epc;
      logic [31:0] tg;
      bit          pt;
      logic [31:0] ptg;
      epc = pcs[$urandom_range(7)];
      tg  = ($urandom_range(3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : tgts[$urandom_range(3)];
      pt  = m_pred(epc);
      ptg = m_pred_tgt(epc);
      if ($urandom_range(4) == 0) begin
        pt  = 1'($urandom_range(1));
        ptg = tgts[$urandom_range(3)];
      end
      drive(1'($urandom_range(6) != 0), epc, 1'($urandom_range(6) != 0),
            1'($urandom_range(1)), tg, pt, ptg);
      pc_if = pcs[$urandom_range(7)];
      #1;
      checks++; if (pred_taken !== m_pred(pc_if) || pred_target !== m_pred_tgt(pc_if)) begin
        errors++;
        $display("FAIL rand_lookup n=%0d pc=%h got=%0b/%h exp=%0b/%h", n, pc_if,
                 pred_taken, pred_target, m_pred(pc_if), m_pred_tgt(pc_if));
      end
      checks++; if (mispredict !== m_mp() || redirect_target !== m_redir()) begin
        errors++;
        $display("FAIL rand_resolve n=%0d got=%0b/%h exp=%0b/%h", n,
                 mispredict, redirect_target, m_mp(), m_redir());
      end
      checks++; if (br_count !== m_br || miss_count !== m_miss) begin
        errors++;
        $display("FAIL rand_counters n=%0d got=%0d/%0d exp=%0d/%0d", n,
                 br_count, miss_count, m_br, m_miss);
      end
      cycle();
    end
    idle();
  endtask

  task automatic test_wrap_reset();
    pc_if = 32'hFFFF_FFFC;
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    checks++; if (m_pred(pc_if) == 1'b0 && pred_target !== 32'h0) begin errors++;
      $display("FAIL wrap_target got=%h exp=00000000", pred_target); end
    cycle();
    idle();
    pc_if = 32'h100;
    #1;
    checks++; if (pred_taken !== m_pred(32'h100)) begin errors++;
      $display("FAIL pre_reset_lookup got=%0b exp=%0b", pred_taken, m_pred(32'h100)); end
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin errors++;
      $display("FAIL async_reset_lookup got=%0b/%h exp=0/00000104", pred_taken, pred_target); end
    checks++; if (br_count !== 32'd0 || miss_count !== 32'd0) begin errors++;
      $display("FAIL async_reset_counters got=%0d/%0d exp=0/0", br_count, miss_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (pred_taken !== 1'b0 || br_count !== 32'd0) begin errors++;
      $display("FAIL after_reset got=%0b/%0d exp=0/0", pred_taken, br_count); end
  endtask

  initial begin
    test_reset();
    test_cold_branch();
    test_saturation();
    test_aliasing();
    test_target_change();
    test_same_cycle();
    test_random();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters for the RV32I pipeline. In IF it predicts the next fetch address for the next-PC selector. In EX it checks each resolved control-transfer instruction against the prediction that travelled down the pipeline. On a mismatch it raises a redirect, with the correct address, toward the next-PC selector. It also keeps branch and mispredict statistics for performance reports.

## Interface
- `ENTRY_BITS`, default 6: log2 of the entry count (64 entries).
- `clk`  in  1: core clock, rising edge.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `pc_if`  in  32: IF-stage PC being looked up.
- `pred_taken`  out  1: predicted taken for `pc_if`.
- `pred_target`  out  32: predicted next fetch address for `pc_if`.
- `ex_valid`  in  1: the EX stage holds a real, non-bubble, non-flushed instruction.
- `ex_pc`  in  32: PC of the EX instruction.
- `ex_is_br`  in  1: the EX instruction is a br, jal or jalr.
- `ex_taken`  in  1: the resolved outcome is taken.
- `ex_target`  in  32: the resolved target.
- `ex_pred_taken`  in  1: `pred_taken` for this instruction, carried through the pipeline.
- `ex_pred_target`  in  32: `pred_target` for this instruction, carried through the pipeline.
- `mispredict`  out  1: redirect request; it flushes IF/ID and overrides the next PC.
- `redirect_target`  out  32: correct next PC when `mispredict` is 1.
- `br_count`  out  32: number of resolved control-transfer instructions.
- `miss_count`  out  32: number of mispredicts.

## Operation
- Entry fields: `valid`, `tag` = pc[31:ENTRY_BITS+2], `target[31:0]`, `cnt[1:0]`.
- Index = pc[ENTRY_BITS+1:2]. pc[1:0] is ignored.

**Lookup (combinational on stored state)**
- hit_if = valid[idx] && tag matches.
- `pred_taken` = hit_if && cnt[1].
- `pred_target` = `pred_taken` ? target : `pc_if`+4. The +4 is modulo 2^32.

**Resolve (combinational)**
- `upd` = `ex_valid` && `ex_is_br`.
- `mispredict` = `ex_valid` && ( (`ex_is_br` && (`ex_taken` != `ex_pred_taken` || (`ex_taken` && `ex_target` != `ex_pred_target`))) || (!`ex_is_br` && `ex_pred_taken`) ).
- `redirect_target` = (`ex_is_br` && `ex_taken`) ? `ex_target` : `ex_pc`+4.
- When `mispredict` is 0, `redirect_target` is don't-care but must still be driven by the same equation.

**Update (rising edge, only when `upd`)**
- Hit at the EX index, taken: `cnt` increments, saturating at 2'b11. `target` <= `ex_target`.
- Hit at the EX index, not taken: `cnt` decrements, saturating at 2'b00. `target` is unchanged.
- Miss, taken: allocate the entry, overwriting any valid occupant. `valid`=1, `tag`, `target` <= `ex_target`, `cnt` <= 2'b10.
- Miss, not taken: no change.
- `br_count` += 1 on every `upd`. `miss_count` += 1 on every `mispredict`, including the non-branch case.
- Both statistics counters saturate at 32'hFFFF_FFFF and never wrap.

**Reset (async, `rst_n`=0)**
- All `valid` = 0, all `cnt` = 2'b01, `br_count` = 0, `miss_count` = 0.
- `tag` and `target` need no reset.
- Output values during reset:
  - `pred_taken` = 0, `pred_target` = `pc_if`+4.
  - `mispredict` follows the EX inputs.
  - Both statistics counters read 0.
- Reset asserted mid-operation discards every entry immediately. A write in flight on that edge is lost.

## Timing
- Lookup latency: 0 cycles, combinational from `pc_if` and registered state. The lookup has no write bypass: a lookup and an update to the same index in the same cycle return the pre-update entry. The update is visible from the next cycle.
- `mispredict` and `redirect_target` are combinational in the EX cycle. The next-PC selector must give `mispredict` priority over the IF prediction.
- Statistics update on the same edge as the table write. The new values are visible the cycle after resolve.
- `ex_valid`=0 means no table write, no counting and `mispredict`=0, whatever the other EX inputs are.
- All state changes occur on rising `clk`, except the asynchronous reset.

## Test plan
- **Reset, then a cold branch.** Reset, then `pc_if`=0x100 → `pred_taken`=0, `pred_target`=0x104. Resolve `ex_pc`=0x100, taken, target 0x80, pred 0 → `mispredict`=1, `redirect_target`=0x80. Next cycle, `pc_if`=0x100 → `pred_taken`=1, `pred_target`=0x80, `br_count`=1, `miss_count`=1.
- **Counter saturation.** Resolve 0x100 taken 3 times → `cnt`=11. Then not-taken once → still predicts taken (`cnt`=10). Not-taken again (`cnt`=01) → `pred_taken`=0, `pred_target`=0x104. Not-taken twice more → `cnt` stays 00.
- **Aliasing.** With ENTRY_BITS=6, allocate 0x100 taken to 0x80. Then resolve 0x200 (same index, different tag) taken to 0x40 → lookup 0x100 misses (`pred_taken`=0), lookup 0x200 predicts 0x40.
- **Target change on a hit.** Entry 0x100→0x80 with `cnt`=11. Resolve taken to 0xC0 with pred target 0x80 → `mispredict`=1, `redirect_target`=0xC0. Next lookup gives 0xC0.
- **Same-cycle read/write and `ex_valid`=0.** Lookup 0x100 in the same cycle as its first allocation → `pred_taken`=0. With `ex_valid`=0, `ex_is_br`=1 and `ex_pred_taken`=1 → `mispredict`=0 and the counters are unchanged.
- **Wrap and reset mid-run.** `pc_if`=0xFFFF_FFFC on a miss → `pred_target`=0x0. Assert `rst_n` low asynchronously between edges → `pred_taken` drops to 0 immediately and `br_count`=0.
